// File: rtl/fp_add_operand_feeder_if.sv
// Operand-feeder bus: upstream valid/ready operand pairs and the issue-side adder operands.
// The slave modport is the feeder's side of the bus.
interface fp_add_operand_feeder_if #(
    parameter logic [1:0]  s     = 2'b00,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned REG_SIZE = (s == 2'b00) ? 16 : (s == 2'b01) ? 32 : 64;
    localparam int unsigned CW       = $clog2(DEPTH) + 1;

    logic [REG_SIZE-1:0] inA_44;
    logic [REG_SIZE-1:0] inB_44;
    logic                in_valid_44;
    logic                in_ready_44;
    logic [REG_SIZE-1:0] addIn1_44;
    logic [REG_SIZE-1:0] addIn2_44;
    logic                issue_valid_44;
    logic                swap_44;
    logic [2:0]          special_44;
    logic [CW-1:0]       count_44;

    modport master (
        output inA_44, inB_44, in_valid_44,
        input  in_ready_44, addIn1_44, addIn2_44, issue_valid_44, swap_44, special_44, count_44
    );

    modport slave (
        input  inA_44, inB_44, in_valid_44,
        output in_ready_44, addIn1_44, addIn2_44, issue_valid_44, swap_44, special_44, count_44
    );
endinterface

// File: rtl/fp_add_operand_feeder.sv
// Issue stage for the FP adder: buffers operand pairs, orders them by magnitude,
// flags NaN/Inf/zero and holds each pair on the adder inputs for HOLD cycles.
module fp_add_operand_feeder #(
    parameter logic [1:0]  s     = 2'b00,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned HOLD  = 8
) (
    input logic                    clk_44,
    input logic                    reset_44,
    fp_add_operand_feeder_if.slave bus
);
    localparam int unsigned REG_SIZE = (s == 2'b00) ? 16 : (s == 2'b01) ? 32 : 64;
    localparam int unsigned EXP_SIZE = (s == 2'b00) ? 5 : (s == 2'b01) ? 8 : 11;
    localparam int unsigned FRA_SIZE = REG_SIZE - EXP_SIZE - 1;
    localparam int unsigned PW       = $clog2(DEPTH);
    localparam int unsigned CW       = PW + 1;
    localparam int unsigned HW       = $clog2(HOLD);

    typedef enum logic [0:0] {StIdle, StHold} state_e;

    state_e                state_q, state_d;
    logic [2*REG_SIZE-1:0] mem_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         count_q, count_d;
    logic [HW-1:0]         hold_q, hold_d;
    logic                  push, load;

    logic [2*REG_SIZE-1:0] head;
    logic [REG_SIZE-1:0]   head_a, head_b, big_d, small_d;
    logic                  swap_d;
    logic [2:0]            special_d, class_a, class_b;

    logic [REG_SIZE-1:0]   add1_q, add2_q;
    logic                  swap_q, issue_q;
    logic [2:0]            special_q;

    // Returns {nan, inf, zero} for one operand.
    function automatic logic [2:0] classify(input logic [REG_SIZE-1:0] x);
        logic exp_ones, frac_zero;
        exp_ones  = &x[REG_SIZE-2 -: EXP_SIZE];
        frac_zero = ~|x[FRA_SIZE-1:0];
        return {exp_ones & ~frac_zero, exp_ones & frac_zero, ~|x[REG_SIZE-2:0]};
    endfunction

    assign bus.in_ready_44 = (count_q < CW'(DEPTH));
    assign push            = bus.in_valid_44 && bus.in_ready_44;

    always_comb begin
        head    = mem_q[rd_ptr_q];
        head_a  = head[2*REG_SIZE-1 -: REG_SIZE];
        head_b  = head[REG_SIZE-1:0];
        // Exponent-then-fraction ordering collapses to one unsigned compare of the non-sign bits.
        swap_d  = head_b[REG_SIZE-2:0] > head_a[REG_SIZE-2:0];
        big_d   = swap_d ? head_b : head_a;
        small_d = swap_d ? head_a : head_b;
        class_a = classify(head_a);
        class_b = classify(head_b);
        special_d = {class_a[2] | class_b[2], class_a[1] | class_b[1], class_a[0] & class_b[0]};
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        load    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (count_q != '0) begin
                    load    = 1'b1;
                    state_d = StHold;
                end
            end
            StHold: begin
                if (hold_q == '0) begin
                    if (count_q != '0) begin
                        load = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    hold_d = hold_q - HW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
        if (load) begin
            hold_d = HW'(HOLD - 1);
        end
        count_d = count_q + CW'(push) - CW'(load);
    end

    always_ff @(posedge clk_44) begin
        if (!reset_44 && push) begin
            mem_q[wr_ptr_q] <= {bus.inA_44, bus.inB_44};
        end
    end

    always_ff @(posedge clk_44) begin
        if (reset_44) begin
            state_q   <= StIdle;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            hold_q    <= '0;
            issue_q   <= 1'b0;
            add1_q    <= '0;
            add2_q    <= '0;
            swap_q    <= 1'b0;
            special_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            hold_q  <= hold_d;
            issue_q <= load;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (load) begin
                rd_ptr_q  <= rd_ptr_q + PW'(1);
                add1_q    <= big_d;
                add2_q    <= small_d;
                swap_q    <= swap_d;
                special_q <= special_d;
            end
        end
    end

    assign bus.addIn1_44      = add1_q;
    assign bus.addIn2_44      = add2_q;
    assign bus.swap_44        = swap_q;
    assign bus.special_44     = special_q;
    assign bus.issue_valid_44 = issue_q;
    assign bus.count_44       = count_q;
endmodule

// File: tb/tb_fp_add_operand_feeder.sv
// Randomized bench for fp_add_operand_feeder: a queue-plus-schedule reference model
// predicts issue times, FIFO occupancy and the ordered/classified operands.
module tb_fp_add_operand_feeder;
    localparam int DEPTH = 4;
    localparam int HOLD  = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fp_add_operand_feeder_if #(.s(2'b00), .DEPTH(DEPTH)) bus16 ();
    fp_add_operand_feeder_if #(.s(2'b01), .DEPTH(DEPTH)) bus32 ();

    fp_add_operand_feeder #(.s(2'b00), .DEPTH(DEPTH), .HOLD(HOLD)) u_dut16 (
        .clk_44   (clk),
        .reset_44 (rst),
        .bus      (bus16.slave)
    );

    fp_add_operand_feeder #(.s(2'b01), .DEPTH(DEPTH), .HOLD(HOLD)) u_dut32 (
        .clk_44   (clk),
        .reset_44 (rst),
        .bus      (bus32.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: pending pairs with their push edge, last issue edge, held outputs.
    logic [31:0] q_pair[$];
    int          q_edge[$];
    int          edge_n     = 0;
    int          last_issue = -1000;
    logic [15:0] e_add1, e_add2;
    logic        e_swap, e_iv;
    logic [2:0]  e_spec;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    function automatic logic [2:0] classify16(input logic [15:0] x);
        int e, f, m;
        e = (int'(x) / 1024) % 32;
        f = int'(x) % 1024;
        m = int'(x) % 32768;
        return {e == 31 && f != 0, e == 31 && f == 0, m == 0};
    endfunction

    task automatic ref_issue(input logic [15:0] a, input logic [15:0] b,
                             output logic [15:0] x1, output logic [15:0] x2,
                             output logic sw, output logic [2:0] sp);
        logic [2:0] ca, cb;
        int ma, mb;
        ma = int'(a) % 32768;
        mb = int'(b) % 32768;
        if (mb > ma) begin
            x1 = b; x2 = a; sw = 1'b1;
        end else begin
            x1 = a; x2 = b; sw = 1'b0;
        end
        ca = classify16(a);
        cb = classify16(b);
        sp = {ca[2] | cb[2], ca[1] | cb[1], ca[0] & cb[0]};
    endtask

    function automatic logic [15:0] rand_op();
        logic [15:0] r;
        r = 16'($urandom);
        case ($urandom_range(0, 7))
            0:       return {r[15], 5'h1F, (r[9:0] == 10'h0) ? 10'h1 : r[9:0]};
            1:       return {r[15], 5'h1F, 10'h0};
            2:       return {r[15], 15'h0};
            3:       return {r[15], 5'h0, r[9:0]};
            default: return r;
        endcase
    endfunction

    task automatic check_outputs();
        check("issue_valid", bus16.issue_valid_44, e_iv);
        check("count", bus16.count_44, q_pair.size());
        check("addIn1", bus16.addIn1_44, e_add1);
        check("addIn2", bus16.addIn2_44, e_add2);
        check("swap", bus16.swap_44, e_swap);
        check("special", bus16.special_44, e_spec);
    endtask

    // One clock: drive at negedge, model the edge, check at the following negedge.
    task automatic cycle(input logic v, input logic [15:0] a, input logic [15:0] b,
                         output logic pushed);
        int sched;
        bus16.in_valid_44 = v;
        bus16.inA_44      = a;
        bus16.inB_44      = b;
        #1;
        check("in_ready", bus16.in_ready_44, q_pair.size() < DEPTH);
        pushed = v && (q_pair.size() < DEPTH);
        @(posedge clk);
        edge_n++;
        e_iv = 1'b0;
        if (q_pair.size() > 0) begin
            sched = q_edge[0] + 1;
            if (last_issue + HOLD > sched) sched = last_issue + HOLD;
            if (sched == edge_n) begin
                ref_issue(q_pair[0][31:16], q_pair[0][15:0], e_add1, e_add2, e_swap, e_spec);
                void'(q_pair.pop_front());
                void'(q_edge.pop_front());
                e_iv       = 1'b1;
                last_issue = edge_n;
            end
        end
        if (pushed) begin
            q_pair.push_back({a, b});
            q_edge.push_back(edge_n);
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset(input logic v);
        rst               = 1'b1;
        bus16.in_valid_44 = v;
        bus16.inA_44      = rand_op();
        bus16.inB_44      = rand_op();
        @(posedge clk);
        edge_n++;
        q_pair.delete();
        q_edge.delete();
        last_issue = -1000;
        e_add1 = '0; e_add2 = '0; e_swap = 1'b0; e_spec = '0; e_iv = 1'b0;
        @(negedge clk);
        rst               = 1'b0;
        bus16.in_valid_44 = 1'b0;
        check("rst_ready", bus16.in_ready_44, 1'b1);
        check_outputs();
    endtask

    task automatic idle(input int n);
        logic p;
        for (int k = 0; k < n; k++) cycle(1'b0, 16'h0, 16'h0, p);
    endtask

    logic [15:0] dir_a [6] = '{16'h2E66, 16'hCB80, 16'h4E46, 16'h7E00, 16'h7C00, 16'h0000};
    logic [15:0] dir_b [6] = '{16'hB800, 16'h4200, 16'hCE46, 16'h3C00, 16'h3C00, 16'h8000};

    initial begin
        logic p;
        int   i, guard;
        logic [15:0] a, b;
        bus16.in_valid_44 = 1'b0; bus16.inA_44 = '0; bus16.inB_44 = '0;
        bus32.in_valid_44 = 1'b0; bus32.inA_44 = '0; bus32.inB_44 = '0;
        @(negedge clk);
        do_reset(1'b1);

        // Directed pairs: swap, no swap, equal magnitude, NaN, Inf, both zero.
        cycle(1'b1, dir_a[0], dir_b[0], p);
        cycle(1'b0, 16'h0, 16'h0, p);
        check("tp_add1", bus16.addIn1_44, 16'hB800);
        check("tp_add2", bus16.addIn2_44, 16'h2E66);
        check("tp_swap", bus16.swap_44, 1'b1);
        check("tp_iv", bus16.issue_valid_44, 1'b1);
        idle(12);
        for (int k = 1; k < 6; k++) begin
            cycle(1'b1, dir_a[k], dir_b[k], p);
            idle(12);
        end
        check("tp_zero_spec", bus16.special_44, 3'b001);

        // Burst of six with in_valid held until each pair is accepted.
        i = 0; guard = 0;
        while (i < 6 && guard < 200) begin
            a = rand_op(); b = rand_op();
            cycle(1'b1, 16'h1000 + 16'(i), 16'h0800 + 16'(i), p);
            if (p) i++;
            guard++;
        end
        check("burst_accepted", i, 6);
        idle(60);

        // Reset a few cycles into a hold with three pairs buffered.
        for (int k = 0; k < 4; k++) cycle(1'b1, rand_op(), rand_op(), p);
        check("pre_rst_count", bus16.count_44, 3);
        do_reset(1'b1);
        idle(20);

        // Random traffic with one mid-run reset.
        for (int k = 0; k < 800; k++) begin
            if (k == 400) do_reset(1'($urandom_range(0, 1)));
            a = rand_op();
            b = ($urandom_range(0, 7) == 0) ? (a ^ 16'h8000) : rand_op();
            cycle($urandom_range(0, 9) < 4, a, b, p);
        end
        idle(50);

        // Single-precision swap case on the second instance.
        check("s32_ready", bus32.in_ready_44, 1'b1);
        bus32.inA_44 = 32'hC1E8E148;
        bus32.inB_44 = 32'h4251B852;
        bus32.in_valid_44 = 1'b1;
        @(negedge clk);
        bus32.in_valid_44 = 1'b0;
        @(negedge clk);
        check("s32_iv", bus32.issue_valid_44, 1'b1);
        check("s32_swap", bus32.swap_44, 1'b1);
        check("s32_add1", bus32.addIn1_44, 32'h4251B852);
        check("s32_add2", bus32.addIn2_44, 32'hC1E8E148);
        check("s32_special", bus32.special_44, 3'b000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/fp_add_operand_feeder.md
Name: fp_add_operand_feeder

Overview:
- Upstream issue stage for the floating-point adder.
- Accepts operand pairs over a valid/ready handshake and buffers them in a small FIFO.
- Issues each pair to the adder's addIn1_44/addIn2_44 and holds it steady for a fixed number of cycles, so the free-running adder pipeline produces a stable result.
- Before issue, orders each pair so the larger-magnitude operand goes on addIn1_44, and flags IEEE special cases.

Parameters:
- s, 2'b00, format select: 00 half (16b, exp 5, frac 10), 01 single (32b, 8, 23), 1x double (64b, 11, 52). REG_SIZE/EXP_SIZE/FRA_SIZE are derived from s exactly as in the adder.
- DEPTH, 4, FIFO entries (power of two, >=2).
- HOLD, 8, cycles each issued pair is held on the outputs (>=2).

Ports:
- clk_44  in  1  clock; all state updates on rising edge.
- reset_44  in  1  synchronous, active-high reset.
- inA_44  in  REG_SIZE  operand A.
- inB_44  in  REG_SIZE  operand B.
- in_valid_44  in  1  operand pair present.
- in_ready_44  out  1  FIFO can accept; equals (count_44 < DEPTH), combinational from count.
- addIn1_44  out  REG_SIZE  larger-magnitude operand to adder (registered).
- addIn2_44  out  REG_SIZE  smaller-magnitude operand to adder (registered).
- issue_valid_44  out  1  one-cycle pulse when a new pair appears on addIn1_44/addIn2_44.
- swap_44  out  1  1 if the current pair was swapped (B drives addIn1_44).
- special_44  out  3  {any_nan, any_inf, both_zero} for the current pair.
- count_44  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (reset_44=1 at an edge), all registered:
  - addIn1_44=0, addIn2_44=0, issue_valid_44=0, swap_44=0, special_44=0, count_44=0.
  - FIFO pointers are 0 and the FSM goes to IDLE.
  - Reset overrides a simultaneous push or pop.
  - Reset mid-HOLD drops the pair being held and every buffered pair.
- Push: occurs at an edge when in_valid_44 && in_ready_44. Stores {inA_44, inB_44} at the write pointer; the pointer wraps modulo DEPTH.
  - When full, in_ready_44=0 and the pair is not stored. There is no same-cycle bypass even if a pop occurs that edge.
- Pop and push on the same edge: count_44 is unchanged.
- FSM states:
  - IDLE:
    - If count_44>0: load the head entry into the output registers, pop it, set issue_valid_44=1, load the hold counter with HOLD-1, and go to HOLD.
    - Otherwise stay in IDLE.
  - HOLD:
    - issue_valid_44=0 after the first cycle; the hold counter decrements each edge.
    - When the counter is 0 and count_44>0: load and pop the next pair, pulse issue_valid_44, reload the counter, and stay in HOLD.
    - When the counter is 0 and the FIFO is empty: go to IDLE.
- Output hold: in IDLE, addIn1_44, addIn2_44, swap_44 and special_44 keep the last issued values.
- Latency:
  - A pair pushed at edge N into an empty FIFO with the FSM in IDLE appears on the outputs after edge N+1, with issue_valid_44=1 for that cycle.
  - Back-to-back issues are exactly HOLD cycles apart.
- Ordering, computed from the FIFO head at load time:
  - Magnitude compare on bits [REG_SIZE-2:0] as unsigned: exponent first, then fraction, which together make one unsigned compare.
  - If mag(B) > mag(A): addIn1_44=B, addIn2_44=A, swap_44=1.
  - Otherwise, including equal magnitudes: addIn1_44=A, addIn2_44=B, swap_44=0.
  - Sign bits travel unchanged with their operand.
- Classification, per operand:
  - exp all-ones with frac != 0 is NaN.
  - exp all-ones with frac == 0 is Inf.
  - bits [REG_SIZE-2:0] == 0 is zero (either sign).
  - any_nan and any_inf are the OR of both operands; both_zero is the AND.
  - All three are registered together with the operands.
- Denormals are passed through unflagged.

Test Plan:
- Reset, then push A=16'h2E66, B=16'hB800 at edge N -> after N+1: addIn1_44=B800, addIn2_44=2E66, swap_44=1, special_44=000, issue_valid_44 high for 1 cycle.
- Push A=CB80, B=4200 -> addIn1_44=CB80, addIn2_44=4200, swap_44=0.
- Push equal magnitudes A=4E46, B=CE46 -> no swap.
- Push A=7E00, B=3C00 -> special_44=100.
- Push A=7C00, B=3C00 -> special_44=010.
- Push A=0000, B=8000 -> special_44=001.
- Push 6 pairs back-to-back with in_valid_44 held high:
  - count_44 reaches 4 and in_ready_44 drops; the stalled pair is not lost once the bench holds it until in_ready_44 rises.
  - issue_valid_44 pulses exactly 8 cycles apart.
  - Output order matches push order, and the write pointer wraps.
- Assert reset_44 for one edge 3 cycles into HOLD with 3 pairs buffered -> next edge: count_44=0, outputs 0, FSM IDLE, in_ready_44=1, no further issue_valid_44 pulses.
- Repeat the swap case with s=2'b01: A=32'hC1E8E148, B=32'h4251B852 -> swap_44=1, addIn1_44=4251B852.
